pc_mt: RTL and testbench
========================

# pc_mt

Multi-thread program counter for the fetch stage: holds one PC per hardware thread and, each cycle, offers one thread's fetch address to instruction memory through a valid/ready handshake. Threads are chosen round-robin among those enabled. Each thread advances by a fixed increment on a successful fetch and can be redirected individually by branch resolution. Sits between the branch/redirect logic and the instruction-memory port, replacing the single-thread PC.

## Interface
- `ADDR_WIDTH`, default 32: PC width in bits.
- `NUM_THREADS`, default 4: thread contexts (≥2, power of two).
- `TID_WIDTH`, default $clog2(NUM_THREADS): thread-id width.
- `clk` in 1: clock.
- `rst` in 1: one clock; reset is asynchronous and active-low.
- `threadEnable` in NUM_THREADS: per-thread run enable, sampled combinationally.
- `addrOut` out ADDR_WIDTH: fetch address of the selected thread.
- `tidOut` out TID_WIDTH: selected thread id.
- `valid` out 1: `addrOut`/`tidOut` carry a fetch request.
- `ready` in 1: consumer accepts; fire = `valid && ready`.
- `wrEnable` in 1: redirect request.
- `wrTid` in TID_WIDTH: thread to redirect.
- `addrIn` in ADDR_WIDTH: redirect target.

## Operation
- State: `pc[NUM_THREADS]`, `rrPtr` (TID_WIDTH), `locked` (1), `lockTid` (TID_WIDTH).
- Reset: every `pc[i]` = `INSN_RESET_VECTOR`, `rrPtr`=0, `locked`=0. Outputs after reset: `valid` = |`threadEnable`; `addrOut` = reset vector.
- Selection: if `locked` and `threadEnable[lockTid]`, sel = `lockTid`. Otherwise, sel = the first enabled thread searching `rrPtr`, `rrPtr`+1, … mod NUM_THREADS. `valid` = any enabled thread. `addrOut` = `pc[sel]`, `tidOut` = sel.
- Lock: when `valid && !ready`, `locked`<=1 and `lockTid`<=sel. Lock clears on fire, or when `threadEnable[lockTid]` drops; reselection happens in that same cycle.
- Fire: `pc[sel]` <= `pc[sel]` + `INSN_PC_INC`, wrapping modulo 2^ADDR_WIDTH. `rrPtr` <= sel+1 (wraps).
- Redirect: `pc[wrTid]` <= `addrIn`. Redirect has priority over the fire increment when `wrTid`==sel. In that case the fire still counts for arbitration: `rrPtr` advances and the lock clears.
- Redirect to a locked, stalled thread: `addrOut` shows the new target the next cycle and the lock is kept.
- No enabled thread: `valid`=0, no state changes except redirects.

## Timing
- `addrOut`/`tidOut`/`valid` are combinational from registered state and `threadEnable`. No path from `ready` or `wrEnable` to outputs.
- Redirect latency: 1 cycle. The written address appears on `addrOut` the cycle after `wrEnable` if that thread is selected.
- Back-to-back fires are allowed every cycle. With all N threads enabled and `ready` held high, each thread fires exactly once per N cycles.
- Asynchronous reset mid-stall drops the lock immediately and restores all PCs.

## Configuration
- `PC_MT_TRAP_EN` defined: adds ports `trap` in 1, `trapTid` in TID_WIDTH, `epcOut` out NUM_THREADS×ADDR_WIDTH, plus per-thread `epc` registers (reset 0).
  - On `trap`: `epc[trapTid]` <= `pc[trapTid]`, and `pc[trapTid]` <= `INSN_TRAP_VECTOR`.
  - `trap` overrides both redirect and increment for that thread. `rrPtr`/lock update as for a redirect.
- Not defined: none of these ports or registers exist; behaviour is as above.

## Structure
- Shared `Types.v` carries `InsnAddrPath`, `INSN_RESET_VECTOR`, `INSN_PC_INC`, `INSN_TRAP_VECTOR` and a `ThreadIdPath` typedef.
- One sub-module, `rr_arbiter`: request vector + pointer in, one-hot/index grant + any-valid out, purely combinational. Reused by later thread-scheduled stages.

## Test plan
- Reset, `threadEnable`=4'b1111, `ready`=1 → `tidOut` sequence 0,1,2,3,0…. Thread 0 addresses 0x0, 0x4, 0x8 on its turns.
- `threadEnable`=4'b0101, `ready`=1 → tids alternate 0,2,0,2; threads 1 and 3 PCs stay at the reset vector.
- `ready`=0 for 3 cycles while tid 1 is selected → `addrOut`/`tidOut` are stable; on release, tid 1 fires once, then tid 2 is selected.
- Stalled on tid 1 at 0x10, with `wrEnable`, `wrTid`=1, `addrIn`=0x400 → next cycle `addrOut`=0x400, still tid 1. Once accepted, tid 1 next offers 0x404.
- Fire on tid 2 and redirect tid 2 to 0x80 in the same cycle → `pc[2]`=0x80, not +4; `rrPtr` advances to 3.
- `PC_MT_TRAP_EN`: trap tid 3 at PC 0x20 → `epcOut[3]`=0x20, next tid 3 fetch is `INSN_TRAP_VECTOR`. A simultaneous redirect to tid 3 is ignored.

Source files
------------

// File: rtl/pc_mt_pkg.sv
// pc_mt_pkg: shared fetch-path types and constants for the multi-thread PC.
//   InsnAddrPath       - instruction address type
//   ThreadIdPath       - thread id type for the default 4-thread build
//   INSN_RESET_VECTOR  - PC value loaded into every thread on reset
//   INSN_PC_INC        - PC advance per accepted fetch
//   INSN_TRAP_VECTOR   - PC loaded on trap (PC_MT_TRAP_EN builds)
package pc_mt_pkg;
  localparam int unsigned INSN_ADDR_WIDTH = 32;

  typedef logic [INSN_ADDR_WIDTH-1:0] InsnAddrPath;
  typedef logic [1:0]                 ThreadIdPath;

  localparam InsnAddrPath INSN_RESET_VECTOR = 32'h0000_0000;
  localparam InsnAddrPath INSN_PC_INC       = 32'h0000_0004;
  localparam InsnAddrPath INSN_TRAP_VECTOR  = 32'h0000_0100;
endpackage

// File: rtl/pc_mt_if.sv
// pc_mt_if: fetch-request and redirect signals of the multi-thread PC.
//   threadEnable     - per-thread run enable
//   addrOut/tidOut   - fetch address and thread id offered to imem
//   valid/ready      - fetch handshake, fire = valid && ready
//   wrEnable/wrTid/addrIn - per-thread redirect
//   trap/trapTid/epcOut   - present only with PC_MT_TRAP_EN defined
// master modport: the PC unit; slave modport: the surrounding pipeline.
interface pc_mt_if #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned NUM_THREADS = 4,
  parameter int unsigned TID_WIDTH   = $clog2(NUM_THREADS)
);
  logic [NUM_THREADS-1:0] threadEnable;
  logic [ADDR_WIDTH-1:0]  addrOut;
  logic [TID_WIDTH-1:0]   tidOut;
  logic                   valid;
  logic                   ready;
  logic                   wrEnable;
  logic [TID_WIDTH-1:0]   wrTid;
  logic [ADDR_WIDTH-1:0]  addrIn;
`ifdef PC_MT_TRAP_EN
  logic                                    trap;
  logic [TID_WIDTH-1:0]                    trapTid;
  logic [NUM_THREADS-1:0][ADDR_WIDTH-1:0]  epcOut;
`endif

  modport master (
    input  threadEnable, ready, wrEnable, wrTid, addrIn,
    output addrOut, tidOut, valid
`ifdef PC_MT_TRAP_EN
    , input trap, trapTid,
    output epcOut
`endif
  );

  modport slave (
    output threadEnable, ready, wrEnable, wrTid, addrIn,
    input  addrOut, tidOut, valid
`ifdef PC_MT_TRAP_EN
    , output trap, trapTid,
    input  epcOut
`endif
  );
endinterface

// File: rtl/pc_mt_rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter.
//   i_req  - request vector
//   i_ptr  - highest-priority index; search runs i_ptr, i_ptr+1, ... mod N
//   o_gnt  - one-hot grant
//   o_idx  - grant index (0 when nothing requests)
//   o_any  - at least one request present
// N must be a power of two so the index wraps by truncation.
module rr_arbiter #(
  parameter int unsigned N = 4,
  parameter int unsigned W = $clog2(N)
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_ptr,
  output logic [N-1:0] o_gnt,
  output logic [W-1:0] o_idx,
  output logic         o_any
);
  logic [W-1:0] w_cand;

  always_comb begin
    o_gnt  = '0;
    o_idx  = '0;
    o_any  = 1'b0;
    w_cand = '0;
    for (int unsigned k = 0; k < N; k++) begin
      w_cand = i_ptr + W'(k);
      if (!o_any && i_req[w_cand]) begin
        o_any = 1'b1;
        o_idx = w_cand;
      end
    end
    o_gnt[o_idx] = o_any;
  end
endmodule

// File: rtl/pc_mt.sv
// pc_mt: multi-thread program counter for the fetch stage.
//   clk  - clock
//   rst  - asynchronous active-low reset
//   bus  - pc_mt_if.master: threadEnable in, addrOut/tidOut/valid out,
//          ready in, wrEnable/wrTid/addrIn redirect in
// Optional feature macro PC_MT_TRAP_EN adds trap/trapTid inputs, epcOut
// output and per-thread EPC registers.
// Outputs depend only on registered state and threadEnable.
module pc_mt
  import pc_mt_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned NUM_THREADS = 4,
  parameter int unsigned TID_WIDTH   = $clog2(NUM_THREADS)
) (
  input  logic     clk,
  input  logic     rst,
  pc_mt_if.master  bus
);
  localparam logic [ADDR_WIDTH-1:0] LP_RST  = ADDR_WIDTH'(INSN_RESET_VECTOR);
  localparam logic [ADDR_WIDTH-1:0] LP_INC  = ADDR_WIDTH'(INSN_PC_INC);
  localparam logic [ADDR_WIDTH-1:0] LP_TRAP = ADDR_WIDTH'(INSN_TRAP_VECTOR);

  logic [ADDR_WIDTH-1:0]  r_pc [NUM_THREADS];
  logic [TID_WIDTH-1:0]   r_rrPtr;
  logic                   r_locked;
  logic [TID_WIDTH-1:0]   r_lockTid;

  logic [NUM_THREADS-1:0] w_gnt;
  logic [TID_WIDTH-1:0]   w_arbIdx;
  logic                   w_any;
  logic                   w_lockHit;
  logic [TID_WIDTH-1:0]   w_sel;
  logic                   w_fire;
  logic [NUM_THREADS-1:0] w_trapHit;

  rr_arbiter #(.N(NUM_THREADS), .W(TID_WIDTH)) u_arb (
    .i_req (bus.threadEnable),
    .i_ptr (r_rrPtr),
    .o_gnt (w_gnt),
    .o_idx (w_arbIdx),
    .o_any (w_any)
  );

  // A stalled request stays on its thread until it fires or that thread is
  // disabled; the latter falls straight through to a fresh arbitration.
  assign w_lockHit = r_locked && bus.threadEnable[r_lockTid];
  assign w_sel     = w_lockHit ? r_lockTid : w_arbIdx;
  assign w_fire    = w_any && bus.ready;

  assign bus.valid   = w_any;
  assign bus.tidOut  = w_sel;
  assign bus.addrOut = r_pc[w_sel];

`ifdef PC_MT_TRAP_EN
  logic [NUM_THREADS-1:0][ADDR_WIDTH-1:0] r_epc;

  always_comb begin
    w_trapHit = '0;
    for (int unsigned i = 0; i < NUM_THREADS; i++)
      w_trapHit[i] = bus.trap && (bus.trapTid == TID_WIDTH'(i));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_epc <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_THREADS; i++)
        if (w_trapHit[i]) r_epc[i] <= r_pc[i];
    end
  end

  assign bus.epcOut = r_epc;
`else
  assign w_trapHit = '0;
`endif

  // Per-thread PC: trap > redirect > fire increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NUM_THREADS; i++) r_pc[i] <= LP_RST;
    end else begin
      for (int unsigned i = 0; i < NUM_THREADS; i++) begin
        if (w_trapHit[i])
          r_pc[i] <= LP_TRAP;
        else if (bus.wrEnable && (bus.wrTid == TID_WIDTH'(i)))
          r_pc[i] <= bus.addrIn;
        else if (w_fire && (w_sel == TID_WIDTH'(i)))
          r_pc[i] <= r_pc[i] + LP_INC;
      end
    end
  end

  // Arbitration state; a fire overridden by redirect/trap still counts here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rrPtr   <= '0;
      r_locked  <= 1'b0;
      r_lockTid <= '0;
    end else if (w_any) begin
      if (bus.ready) begin
        r_locked <= 1'b0;
        r_rrPtr  <= w_sel + TID_WIDTH'(1);
      end else begin
        r_locked  <= 1'b1;
        r_lockTid <= w_sel;
      end
    end else begin
      r_locked <= 1'b0;
    end
  end

  logic w_unused;
  assign w_unused = ^w_gnt;
endmodule

// File: tb/tb_pc_mt.sv
module tb_pc_mt;
  import pc_mt_pkg::*;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int TW = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pc_mt_if #(.ADDR_WIDTH(AW), .NUM_THREADS(N), .TID_WIDTH(TW)) bus ();

  pc_mt #(.ADDR_WIDTH(AW), .NUM_THREADS(N), .TID_WIDTH(TW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [AW-1:0] m_pc  [N];
  logic [AW-1:0] m_epc [N];
  int            m_rr;
  bit            m_locked;
  int            m_lockTid;
  bit            m_valid;
  int            m_sel;

`ifdef PC_MT_TRAP_EN
  logic          trap_q    = 1'b0;
  logic [TW-1:0] trapTid_q = '0;
`endif

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_pc[i]  = INSN_RESET_VECTOR;
      m_epc[i] = '0;
    end
    m_rr = 0; m_locked = 0; m_lockTid = 0;
  endtask

  // Which thread must be offered: the held one if still enabled, else the
  // first enabled thread at or after the round-robin pointer.
  task automatic model_eval();
    m_valid = 0; m_sel = 0;
    if (m_locked && bus.threadEnable[m_lockTid]) begin
      m_valid = 1; m_sel = m_lockTid;
    end else begin
      for (int k = 0; k < N; k++) begin
        int t;
        t = (m_rr + k) % N;
        if (!m_valid && bus.threadEnable[t]) begin
          m_valid = 1; m_sel = t;
        end
      end
    end
  endtask

  task automatic model_compare();
    model_eval();
    chk("valid", 64'(bus.valid), 64'(m_valid));
    if (m_valid) begin
      chk("tidOut",  64'(bus.tidOut),  64'(m_sel));
      chk("addrOut", 64'(bus.addrOut), 64'(m_pc[m_sel]));
    end
`ifdef PC_MT_TRAP_EN
    for (int i = 0; i < N; i++) chk("epcOut", 64'(bus.epcOut[i]), 64'(m_epc[i]));
`endif
  endtask

  task automatic model_tick();
    logic [AW-1:0] old [N];
    bit fire;
    for (int i = 0; i < N; i++) old[i] = m_pc[i];
    fire = m_valid && bus.ready;
    for (int i = 0; i < N; i++) begin
`ifdef PC_MT_TRAP_EN
      if (trap_q && int'(trapTid_q) == i) begin
        m_epc[i] = old[i];
        m_pc[i]  = INSN_TRAP_VECTOR;
        continue;
      end
`endif
      if (bus.wrEnable && int'(bus.wrTid) == i) m_pc[i] = bus.addrIn;
      else if (fire && m_sel == i)              m_pc[i] = old[i] + INSN_PC_INC;
    end
    if (m_valid) begin
      if (bus.ready) begin
        m_locked = 0; m_rr = (m_sel + 1) % N;
      end else begin
        m_locked = 1; m_lockTid = m_sel;
      end
    end else begin
      m_locked = 0;
    end
  endtask

  // One cycle: drive at negedge, compare against model (plus optional
  // literal tid/addr expectation), then advance model at posedge.
  task automatic run(input logic [N-1:0] en, input bit rdy, input bit we,
                     input int wt, input logic [AW-1:0] ai,
                     input int lt, input longint la);
    @(negedge clk);
    bus.threadEnable = en;
    bus.ready        = rdy;
    bus.wrEnable     = we;
    bus.wrTid        = TW'(wt);
    bus.addrIn       = ai;
`ifdef PC_MT_TRAP_EN
    bus.trap         = trap_q;
    bus.trapTid      = trapTid_q;
`endif
    #1;
    model_compare();
    if (lt >= 0) begin
      chk("lit_tid",  64'(bus.tidOut),  64'(lt));
      chk("lit_addr", 64'(bus.addrOut), 64'(la));
    end
    @(posedge clk);
    model_tick();
  endtask

  // Assumes rst is already low; releases it with all threads disabled so
  // the first post-reset edge changes nothing.
  task automatic release_reset();
    bus.threadEnable = '0;
    bus.ready        = 1'b0;
    bus.wrEnable     = 1'b0;
`ifdef PC_MT_TRAP_EN
    trap_q   = 1'b0;
    bus.trap = 1'b0;
`endif
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    release_reset();
  endtask

  localparam logic [N-1:0] ALL = 4'b1111;

  initial begin
    bus.threadEnable = '0; bus.ready = 1'b0; bus.wrEnable = 1'b0;
    bus.wrTid = '0; bus.addrIn = '0;
`ifdef PC_MT_TRAP_EN
    bus.trap = 1'b0; bus.trapTid = '0;
`endif
    release_reset();

    // All enabled, ready high: strict rotation, PC advances by 4 per turn.
    for (int c = 0; c < 9; c++) run(ALL, 1, 0, 0, 0, c % 4, (c / 4) * 4);

    // Threads 0 and 2 only; 1 and 3 keep the reset vector.
    do_reset();
    for (int c = 0; c < 6; c++) run(4'b0101, 1, 0, 0, 0, (c % 2) * 2, (c / 2) * 4);
    run(4'b0010, 0, 0, 0, 0, 1, 0);
    run(4'b1000, 0, 0, 0, 0, 3, 0);   // held thread 1 disabled -> reselect

    // Stall, redirect while stalled, redirect colliding with a fire.
    do_reset();
    run(ALL, 1, 0, 0, 0,       0, 0);
    run(ALL, 1, 0, 0, 0,       1, 0);
    run(ALL, 1, 0, 0, 0,       2, 0);
    run(ALL, 1, 0, 0, 0,       3, 0);
    run(ALL, 1, 0, 0, 0,       0, 4);
    run(ALL, 0, 0, 0, 0,       1, 4);
    run(ALL, 0, 1, 1, 'h400,   1, 4);
    run(ALL, 0, 0, 0, 0,       1, 'h400);
    run(ALL, 1, 0, 0, 0,       1, 'h400);
    run(ALL, 1, 1, 2, 'h80,    2, 4);
    run(ALL, 1, 0, 0, 0,       3, 4);
    run(ALL, 1, 0, 0, 0,       0, 8);
    run(ALL, 1, 0, 0, 0,       1, 'h404);
    run(ALL, 1, 0, 0, 0,       2, 'h80);

    // Asynchronous reset in the middle of a stall on thread 3.
    run(ALL, 0, 0, 0, 0, 3, 8);
    @(negedge clk);
    bus.threadEnable = ALL; bus.ready = 1'b0; bus.wrEnable = 1'b0;
    #2 rst = 1'b0;
    #1;
    model_reset();
    chk("arst_valid", 64'(bus.valid),   64'd1);
    chk("arst_tid",   64'(bus.tidOut),  64'd0);
    chk("arst_addr",  64'(bus.addrOut), 64'h0);
    release_reset();

    // Randomized traffic against the model.
    for (int c = 0; c < 600; c++) begin
      logic [N-1:0] en;
      en = ($urandom_range(0, 4) == 0) ? ALL : N'($urandom);
      run(en, $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
          $urandom_range(0, N - 1), {$urandom, 2'b00} >> 2 << 2, -1, 0);
    end

`ifdef PC_MT_TRAP_EN
    // Trap thread 3 at 0x20 with a conflicting redirect in the same cycle.
    do_reset();
    run(ALL, 0, 1, 3, 'h20, 0, 0);
    trap_q = 1'b1; trapTid_q = 2'd3;
    run(ALL, 0, 1, 3, 'h999, 0, 0);
    trap_q = 1'b0;
    #1;
    chk("epc3", 64'(bus.epcOut[3]), 64'h20);
    run(4'b1000, 1, 0, 0, 0, 3, 'h100);
    run(4'b1000, 1, 0, 0, 0, 3, 'h104);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
